// File: rtl/gate_top.sv
// Half-adder gate cell: combinational AND/XOR plus registered copies,
// a sticky input-combination bitmap and an input-change counter.
module gate_top #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  output logic             and_out,
  output logic             xor_out,
  output logic             and_q,
  output logic             xor_q,
  output logic [3:0]       seen,
  output logic [CNT_W-1:0] chg_cnt
);

  logic [1:0]       ab;
  logic             and_d;
  logic             xor_d;
  logic [3:0]       seen_d, seen_q;
  logic [1:0]       prev_ab_d, prev_ab_q;
  logic             prev_valid_d, prev_valid_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  assign ab      = {a, b};
  assign and_out = a & b;
  assign xor_out = a ^ b;
  assign seen    = seen_q;
  assign chg_cnt = cnt_q;

  always_comb begin
    and_d        = a & b;
    xor_d        = a ^ b;
    seen_d       = seen_q | (4'b0001 << ab);
    prev_ab_d    = ab;
    prev_valid_d = 1'b1;
    cnt_d        = cnt_q;
    // first sample after reset has nothing to compare against
    if (prev_valid_q && (ab != prev_ab_q))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      and_q        <= 1'b0;
      xor_q        <= 1'b0;
      seen_q       <= 4'b0000;
      prev_ab_q    <= 2'b00;
      prev_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      and_q        <= and_d;
      xor_q        <= xor_d;
      seen_q       <= seen_d;
      prev_ab_q    <= prev_ab_d;
      prev_valid_q <= prev_valid_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_gate_top.sv
// Directed self-checking bench for gate_top (default and CNT_W=2 instances).
module tb_gate_top;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic       and_out, xor_out, and_q, xor_q;
  logic [3:0] seen;
  logic [7:0] chg_cnt;
  logic       and_out2, xor_out2, and_q2, xor_q2;
  logic [3:0] seen2;
  logic [1:0] chg_cnt2;

  int n_chk = 0;
  int n_fail = 0;

  gate_top #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b),
    .and_out(and_out), .xor_out(xor_out),
    .and_q(and_q), .xor_q(xor_q),
    .seen(seen), .chg_cnt(chg_cnt)
  );

  gate_top #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b),
    .and_out(and_out2), .xor_out(xor_out2),
    .and_q(and_q2), .xor_q(xor_q2),
    .seen(seen2), .chg_cnt(chg_cnt2)
  );

  always #5 clk = ~clk;

  task automatic step(input logic ia, input logic ib);
    @(negedge clk);
    a = ia;
    b = ib;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_with(input logic ia, input logic ib);
    @(negedge clk);
    rst_n = 1'b0;
    a = ia;
    b = ib;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_comb;
    logic [1:0] exp_t [4];
    exp_t[0] = 2'b00; exp_t[1] = 2'b01;
    exp_t[2] = 2'b01; exp_t[3] = 2'b10;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      {a, b} = 2'(i);
      #10;
      n_chk++;
      if ({and_out, xor_out} !== exp_t[i]) begin
        n_fail++;
        $display("FAIL comb ab=%0d got and,xor=%b need %b", i, {and_out, xor_out}, exp_t[i]);
      end
    end
  endtask

  task automatic test_reset;
    a = 1'b1;
    b = 1'b1;
    rst_n = 1'b0;
    #3;
    n_chk++;
    if ({and_q, xor_q, seen, chg_cnt} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_state got %b,%b,%b,%0d need 0,0,0000,0", and_q, xor_q, seen, chg_cnt);
    end
    n_chk++;
    if ({and_out, xor_out} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_comb got %b need 10", {and_out, xor_out});
    end
  endtask

  task automatic test_first_edge;
    @(negedge clk);
    rst_n = 1'b1;
    a = 1'b1;
    b = 1'b1;
    #1;
    n_chk++;
    if (and_q !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_pre got and_q=%b need 0", and_q);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if ({and_q, xor_q} !== 2'b10) begin
      n_fail++;
      $display("FAIL first_edge got and_q,xor_q=%b need 10", {and_q, xor_q});
    end
    n_chk++;
    if (seen !== 4'b1000 || chg_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL first_seen got seen=%b cnt=%0d need 1000,0", seen, chg_cnt);
    end
  endtask

  task automatic test_sweep;
    reset_with(1'b0, 1'b0);
    n_chk++;
    if (seen !== 4'b0001 || chg_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL sweep0 got seen=%b cnt=%0d need 0001,0", seen, chg_cnt);
    end
    step(1'b0, 1'b1);
    n_chk++;
    if ({and_q, xor_q} !== 2'b01) begin
      n_fail++;
      $display("FAIL sweep01_q got %b need 01", {and_q, xor_q});
    end
    step(1'b1, 1'b0);
    n_chk++;
    if (chg_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL sweep10_cnt got %0d need 2", chg_cnt);
    end
    step(1'b1, 1'b1);
    n_chk++;
    if (seen !== 4'b1111 || chg_cnt !== 8'd3) begin
      n_fail++;
      $display("FAIL sweep_end got seen=%b cnt=%0d need 1111,3", seen, chg_cnt);
    end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    n_chk++;
    if (chg_cnt !== 8'd3 || seen !== 4'b1111) begin
      n_fail++;
      $display("FAIL hold got seen=%b cnt=%0d need 1111,3", seen, chg_cnt);
    end
  endtask

  task automatic test_wrap;
    reset_with(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    n_chk++;
    if (chg_cnt2 !== 2'd3) begin
      n_fail++;
      $display("FAIL wrap_pre got %0d need 3", chg_cnt2);
    end
    step(1'b0, 1'b0);
    n_chk++;
    if (chg_cnt2 !== 2'd0 || chg_cnt !== 8'd4) begin
      n_fail++;
      $display("FAIL wrap_zero got cnt2=%0d cnt=%0d need 0,4", chg_cnt2, chg_cnt);
    end
    step(1'b1, 1'b0);
    n_chk++;
    if (chg_cnt2 !== 2'd1 || chg_cnt !== 8'd5) begin
      n_fail++;
      $display("FAIL wrap_one got cnt2=%0d cnt=%0d need 1,5", chg_cnt2, chg_cnt);
    end
    n_chk++;
    if (seen2 !== 4'b0101) begin
      n_fail++;
      $display("FAIL wrap_seen got %b need 0101", seen2);
    end
  endtask

  task automatic test_async_reset;
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({and_q, xor_q, seen, chg_cnt} !== 14'd0) begin
      n_fail++;
      $display("FAIL async_clr got %b,%b,%b,%0d need 0,0,0000,0", and_q, xor_q, seen, chg_cnt);
    end
    n_chk++;
    if ({and_out, xor_out} !== 2'b01) begin
      n_fail++;
      $display("FAIL async_comb got %b need 01", {and_out, xor_out});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_chk++;
    if (seen !== 4'b0010 || chg_cnt !== 8'd0 || xor_q !== 1'b1) begin
      n_fail++;
      $display("FAIL resume0 got seen=%b cnt=%0d xq=%b need 0010,0,1", seen, chg_cnt, xor_q);
    end
    step(1'b1, 1'b1);
    n_chk++;
    if (seen !== 4'b1010 || chg_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL resume1 got seen=%b cnt=%0d need 1010,1", seen, chg_cnt);
    end
  endtask

  initial begin
    test_comb();
    test_reset();
    test_first_edge();
    test_sweep();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
